// File: rtl/op_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : op_seq_pkg
// Description : Opcodes, control-bit indices, command record and FSM states
//               shared by the op_sequencer command stage.
// Revision    : 1.0 - initial release
// ============================================================================
package op_seq_pkg;

    localparam logic [1:0] OP_NOP      = 2'b00;
    localparam logic [1:0] OP_LOAD     = 2'b01;
    localparam logic [1:0] OP_LOAD_DBL = 2'b10;
    localparam logic [1:0] OP_INC      = 2'b11;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_DBL = 1;
    localparam int CTRL_OP  = 2;

    localparam int CMD_W = 10;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] rpt;
    } cmd_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Datapath control word for one beat of the given opcode.
    function automatic logic [2:0] beat_ctrl(input logic [1:0] op);
        logic [2:0] c;
        c = '0;
        case (op)
            OP_LOAD: begin
                c[CTRL_EN] = 1'b1;
            end
            OP_LOAD_DBL: begin
                c[CTRL_EN]  = 1'b1;
                c[CTRL_DBL] = 1'b1;
            end
            OP_INC: begin
                c[CTRL_EN] = 1'b1;
                c[CTRL_OP] = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Single-clock synchronous FIFO with full/empty/count flags and
//               synchronous active-high reset. No bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;

    // Push qualifies on the registered full flag, so a same-edge pop never frees a slot.
    assign w_push = push && (r_count != FULL_CNT);
    assign w_pop  = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == FULL_CNT);
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : op_sequencer
// Description : Buffers opcode/operand/repeat commands and expands each into
//               registered data/control beats for the shift/increment datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [3:0]                    cmd_data,
    input  logic [3:0]                    cmd_repeat,
    input  logic                          hold,
    output logic [3:0]                    data_out,
    output logic [2:0]                    control_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              issued_inc
);

    cmd_t       w_cmd_in;
    cmd_t       w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_remain;
    logic [3:0] w_remain_nxt;
    logic [1:0] r_cur_op;
    logic [1:0] w_cur_op_nxt;
    logic [3:0] r_cur_data;
    logic [3:0] w_cur_data_nxt;

    logic [3:0]       r_data_out;
    logic [3:0]       w_data_nxt;
    logic [2:0]       r_ctrl_out;
    logic [2:0]       w_ctrl_nxt;
    logic [CNT_W-1:0] r_issued;

    logic       w_beat_vld;
    logic [1:0] w_beat_op;
    logic [3:0] w_beat_data;
    logic       w_inc_beat;

    assign w_cmd_in = '{op: cmd_op, data: cmd_data, rpt: cmd_repeat};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (w_cmd_in),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_remain_nxt   = r_remain;
        w_cur_op_nxt   = r_cur_op;
        w_cur_data_nxt = r_cur_data;
        w_pop          = 1'b0;
        w_beat_vld     = 1'b0;
        w_beat_op      = OP_NOP;
        w_beat_data    = r_cur_data;
        w_ctrl_nxt     = 3'b000;
        w_data_nxt     = r_data_out;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !hold) begin
                    w_pop          = 1'b1;
                    w_cur_op_nxt   = w_head.op;
                    w_cur_data_nxt = w_head.data;
                    w_remain_nxt   = w_head.rpt;
                    w_beat_vld     = 1'b1;
                    w_beat_op      = w_head.op;
                    w_beat_data    = w_head.data;
                    if (w_head.rpt != 4'd0) begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Returning to IDLE after the last beat lets IDLE pop the next command on the very next edge.
                if (!hold) begin
                    w_beat_vld   = 1'b1;
                    w_beat_op    = r_cur_op;
                    w_remain_nxt = r_remain - 4'd1;
                    if (r_remain == 4'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_beat_vld) begin
            w_ctrl_nxt = beat_ctrl(w_beat_op);
            if (w_beat_op == OP_LOAD || w_beat_op == OP_LOAD_DBL) begin
                w_data_nxt = w_beat_data;
            end
        end
    end

    assign w_inc_beat = w_beat_vld && (w_beat_op == OP_INC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_remain   <= '0;
            r_cur_op   <= OP_NOP;
            r_cur_data <= '0;
            r_data_out <= '0;
            r_ctrl_out <= '0;
            r_issued   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_remain   <= w_remain_nxt;
            r_cur_op   <= w_cur_op_nxt;
            r_cur_data <= w_cur_data_nxt;
            r_data_out <= w_data_nxt;
            r_ctrl_out <= w_ctrl_nxt;
            if (w_inc_beat) begin
                r_issued <= r_issued + CNT_W'(1);
            end
        end
    end

    assign cmd_ready   = !w_full;
    assign busy        = (r_state == ST_ISSUE) || !w_empty;
    assign data_out    = r_data_out;
    assign control_out = r_ctrl_out;
    assign issued_inc  = r_issued;

endmodule
`default_nettype wire
